// File: rtl/comparator_pipe.sv
// Registered magnitude comparator with a valid/ready stream interface, run-time
// signed/unsigned mode and saturating per-result statistics counters.
module comparator_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  signed_in,
  input  logic                  cnt_clr_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  a_g_b_out,
  output logic                  a_e_b_out,
  output logic                  a_l_b_out,
  output logic [CNT_WIDTH-1:0]  gt_cnt_out,
  output logic [CNT_WIDTH-1:0]  eq_cnt_out,
  output logic [CNT_WIDTH-1:0]  lt_cnt_out
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_a_key;
  logic [DATA_WIDTH-1:0] w_b_key;
  logic                  w_gt;
  logic                  w_eq;
  logic                  w_lt;

  logic                  r_valid;
  logic                  r_gt;
  logic                  r_eq;
  logic                  r_lt;
  logic [CNT_WIDTH-1:0]  r_gt_cnt;
  logic [CNT_WIDTH-1:0]  r_eq_cnt;
  logic [CNT_WIDTH-1:0]  r_lt_cnt;

  assign ready_out = !r_valid || ready_in;
  assign w_accept  = valid_in && ready_out;

  // Inverting the sign bit in signed mode maps two's-complement order onto unsigned order.
  always_comb begin
    w_a_key = a_in;
    w_b_key = b_in;
    w_a_key[DATA_WIDTH-1] = a_in[DATA_WIDTH-1] ^ signed_in;
    w_b_key[DATA_WIDTH-1] = b_in[DATA_WIDTH-1] ^ signed_in;
  end

  assign w_eq = (a_in == b_in);
  assign w_gt = (w_a_key > w_b_key);
  assign w_lt = !w_eq && !w_gt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_valid <= 1'b0;
      r_gt    <= 1'b0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_gt    <= w_gt;
      r_eq    <= w_eq;
      r_lt    <= w_lt;
    end else if (ready_in) begin
      r_valid <= 1'b0;
    end
  end

  // Clear takes priority over counting a coincident accept.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_gt_cnt <= '0;
      r_eq_cnt <= '0;
      r_lt_cnt <= '0;
    end else if (cnt_clr_in) begin
      r_gt_cnt <= '0;
      r_eq_cnt <= '0;
      r_lt_cnt <= '0;
    end else if (w_accept) begin
      if (w_gt && (r_gt_cnt != CNT_MAX)) r_gt_cnt <= r_gt_cnt + 1'b1;
      if (w_eq && (r_eq_cnt != CNT_MAX)) r_eq_cnt <= r_eq_cnt + 1'b1;
      if (w_lt && (r_lt_cnt != CNT_MAX)) r_lt_cnt <= r_lt_cnt + 1'b1;
    end
  end

  assign valid_out  = r_valid;
  assign a_g_b_out  = r_gt;
  assign a_e_b_out  = r_eq;
  assign a_l_b_out  = r_lt;
  assign gt_cnt_out = r_gt_cnt;
  assign eq_cnt_out = r_eq_cnt;
  assign lt_cnt_out = r_lt_cnt;

endmodule

// File: tb/tb_comparator_pipe.sv
// Testbench for comparator_pipe: three instances (8/4, 1/16, 33/16 data/counter
// widths) share one stimulus bus and are compared with a numeric reference model.
module tb_comparator_pipe;

  logic        clk_in     = 1'b0;
  logic        rst_n_in   = 1'b0;
  logic        valid_in   = 1'b0;
  logic        signed_in  = 1'b0;
  logic        cnt_clr_in = 1'b0;
  logic        ready_in   = 1'b0;
  logic [32:0] a = '0;
  logic [32:0] b = '0;

  logic        v0, r0, g0, e0, l0;
  logic [3:0]  gc0, ec0, lc0;
  logic        v1, r1, g1, e1, l1;
  logic [15:0] gc1, ec1, lc1;
  logic        v2, r2, g2, e2, l2;
  logic [15:0] gc2, ec2, lc2;

  logic        obsV [3];
  logic        obsR [3];
  logic [2:0]  obsF [3];
  logic [15:0] obsGc [3];
  logic [15:0] obsEc [3];
  logic [15:0] obsLc [3];

  bit          mV [3];
  logic [2:0]  mF [3];
  int          mCnt [3][3];
  int          widths [3] = '{8, 1, 33};
  int          cmax [3]   = '{15, 65535, 65535};

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  comparator_pipe #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u0 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .valid_in(valid_in), .ready_out(r0),
    .a_in(a[7:0]), .b_in(b[7:0]), .signed_in(signed_in), .cnt_clr_in(cnt_clr_in),
    .valid_out(v0), .ready_in(ready_in), .a_g_b_out(g0), .a_e_b_out(e0), .a_l_b_out(l0),
    .gt_cnt_out(gc0), .eq_cnt_out(ec0), .lt_cnt_out(lc0));

  comparator_pipe #(.DATA_WIDTH(1), .CNT_WIDTH(16)) u1 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .valid_in(valid_in), .ready_out(r1),
    .a_in(a[0:0]), .b_in(b[0:0]), .signed_in(signed_in), .cnt_clr_in(cnt_clr_in),
    .valid_out(v1), .ready_in(ready_in), .a_g_b_out(g1), .a_e_b_out(e1), .a_l_b_out(l1),
    .gt_cnt_out(gc1), .eq_cnt_out(ec1), .lt_cnt_out(lc1));

  comparator_pipe #(.DATA_WIDTH(33), .CNT_WIDTH(16)) u2 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .valid_in(valid_in), .ready_out(r2),
    .a_in(a), .b_in(b), .signed_in(signed_in), .cnt_clr_in(cnt_clr_in),
    .valid_out(v2), .ready_in(ready_in), .a_g_b_out(g2), .a_e_b_out(e2), .a_l_b_out(l2),
    .gt_cnt_out(gc2), .eq_cnt_out(ec2), .lt_cnt_out(lc2));

  always_comb begin
    obsV[0] = v0; obsR[0] = r0; obsF[0] = {g0, e0, l0};
    obsV[1] = v1; obsR[1] = r1; obsF[1] = {g1, e1, l1};
    obsV[2] = v2; obsR[2] = r2; obsF[2] = {g2, e2, l2};
    obsGc[0] = {12'd0, gc0}; obsEc[0] = {12'd0, ec0}; obsLc[0] = {12'd0, lc0};
    obsGc[1] = gc1; obsEc[1] = ec1; obsLc[1] = lc1;
    obsGc[2] = gc2; obsEc[2] = ec2; obsLc[2] = lc2;
  end

  // Numeric compare: 0 = greater, 1 = equal, 2 = less.
  function automatic int ref_cmp(logic [32:0] x, logic [32:0] y, int w, bit sgn);
    longint m, vx, vy;
    m  = longint'(1) << w;
    vx = longint'({31'd0, x}) & (m - 1);
    vy = longint'({31'd0, y}) & (m - 1);
    if (sgn && vx >= m / 2) vx = vx - m;
    if (sgn && vy >= m / 2) vy = vy - m;
    if (vx > vy) return 0;
    if (vx == vy) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mV[i] = 1'b0;
      mF[i] = 3'b000;
      for (int k = 0; k < 3; k++) mCnt[i][k] = 0;
    end
  endtask

  // Advances one clock and the reference model with the currently driven inputs.
  task automatic tick();
    bit acc [3];
    int res [3];
    #1;
    for (int i = 0; i < 3; i++) begin
      acc[i] = valid_in && (!mV[i] || ready_in);
      res[i] = ref_cmp(a, b, widths[i], signed_in);
    end
    @(posedge clk_in);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (cnt_clr_in) begin
        for (int k = 0; k < 3; k++) mCnt[i][k] = 0;
      end else if (acc[i] && mCnt[i][res[i]] < cmax[i]) begin
        mCnt[i][res[i]]++;
      end
      if (acc[i]) begin
        mV[i] = 1'b1;
        mF[i] = 3'b100 >> res[i];
      end else if (ready_in) begin
        mV[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    valid_in = 1'b0;
    cnt_clr_in = 1'b0;
    model_reset();
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({obsV[i], obsR[i], obsF[i]} !== 5'b01000) begin
        errors++;
        $display("[TB] FAIL reset_state inst%0d got v/r/flags=%b exp=01000", i, {obsV[i], obsR[i], obsF[i]});
      end
      checks++;
      if ({obsGc[i], obsEc[i], obsLc[i]} !== 48'd0) begin
        errors++;
        $display("[TB] FAIL reset_counters inst%0d got %0d/%0d/%0d exp 0/0/0", i, obsGc[i], obsEc[i], obsLc[i]);
      end
    end
  endtask

  task automatic test_mode();
    do_reset();
    ready_in = 1'b1; valid_in = 1'b1;
    a = 33'h80; b = 33'h01; signed_in = 1'b0;
    tick();
    checks++;
    if ({v0, g0, e0, l0, gc0} !== {4'b1100, 4'd1}) begin
      errors++;
      $display("[TB] FAIL mode_unsigned got v/flags=%b gt_cnt=%0d exp 1100 gt_cnt=1", {v0, g0, e0, l0}, gc0);
    end
    signed_in = 1'b1;
    tick();
    checks++;
    if ({v0, g0, e0, l0, lc0} !== {4'b1001, 4'd1}) begin
      errors++;
      $display("[TB] FAIL mode_signed got v/flags=%b lt_cnt=%0d exp 1001 lt_cnt=1", {v0, g0, e0, l0}, lc0);
    end
    a = 33'hFF; b = 33'hFF;
    for (int s = 0; s < 2; s++) begin
      signed_in = s[0];
      tick();
      checks++;
      if ({v0, g0, e0, l0} !== 4'b1010) begin
        errors++;
        $display("[TB] FAIL mode_equal signed=%0d got v/flags=%b exp 1010", s, {v0, g0, e0, l0});
      end
    end
    checks++;
    if (ec0 !== 4'd2) begin
      errors++;
      $display("[TB] FAIL mode_eq_cnt got %0d exp 2", ec0);
    end
    valid_in = 1'b0;
    signed_in = 1'b0;
  endtask

  task automatic test_backpressure();
    int pa [4] = '{5, 3, 1, 200};
    int pb [4] = '{3, 3, 9, 100};
    logic [2:0] expF [4] = '{3'b100, 3'b010, 3'b001, 3'b100};
    logic [2:0] got [$];
    int k;
    bit acc;
    do_reset();
    signed_in = 1'b0; ready_in = 1'b0; valid_in = 1'b1;
    a = 33'(pa[0]); b = 33'(pb[0]);
    tick();
    a = 33'(pa[1]); b = 33'(pb[1]);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({r0, v0, g0, e0, l0} !== 5'b01100) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle%0d got ready/valid/flags=%b exp 01100", c, {r0, v0, g0, e0, l0});
      end
      tick();
    end
    ready_in = 1'b1;
    k = 1;
    for (int c = 0; c < 8; c++) begin
      if (k < 4) begin
        valid_in = 1'b1;
        a = 33'(pa[k]); b = 33'(pb[k]);
      end else begin
        valid_in = 1'b0;
      end
      #1;
      if (v0 && ready_in) got.push_back({g0, e0, l0});
      acc = valid_in && r0;
      tick();
      if (acc) k++;
    end
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("[TB] FAIL bp_count got %0d results exp 4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== expF[i]) begin
        errors++;
        $display("[TB] FAIL bp_order result%0d got %b exp %b", i, got[i], expF[i]);
      end
    end
    checks++;
    if ({gc0, ec0, lc0} !== {4'd2, 4'd1, 4'd1}) begin
      errors++;
      $display("[TB] FAIL bp_counters got %0d/%0d/%0d exp 2/1/1", gc0, ec0, lc0);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    ready_in = 1'b1; valid_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = 33'($urandom);
      b = a;
      signed_in = $urandom_range(0, 1);
      tick();
    end
    valid_in = 1'b0;
    checks++;
    if ({gc0, ec0, lc0} !== {4'd0, 4'd15, 4'd0}) begin
      errors++;
      $display("[TB] FAIL sat_cnt8 got %0d/%0d/%0d exp 0/15/0", gc0, ec0, lc0);
    end
    checks++;
    if (ec1 !== 16'd20) begin
      errors++;
      $display("[TB] FAIL sat_cnt16 got eq=%0d exp 20", ec1);
    end
  endtask

  task automatic test_clear_collision();
    do_reset();
    ready_in = 1'b1; valid_in = 1'b1;
    a = 33'h3C; b = 33'h3C;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (ec0 !== 4'd5) begin
      errors++;
      $display("[TB] FAIL clr_pre got eq=%0d exp 5", ec0);
    end
    cnt_clr_in = 1'b1;
    tick();
    cnt_clr_in = 1'b0;
    checks++;
    if ({ec0, v0, e0} !== {4'd0, 2'b11}) begin
      errors++;
      $display("[TB] FAIL clr_collide got eq=%0d v=%b eqflag=%b exp 0 1 1", ec0, v0, e0);
    end
    tick();
    valid_in = 1'b0;
    checks++;
    if (ec0 !== 4'd1) begin
      errors++;
      $display("[TB] FAIL clr_after got eq=%0d exp 1", ec0);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    ready_in = 1'b0; valid_in = 1'b1; signed_in = 1'b0;
    a = 33'h09; b = 33'h02;
    tick();
    valid_in = 1'b0;
    checks++;
    if ({v0, g0, gc0} !== {2'b11, 4'd1}) begin
      errors++;
      $display("[TB] FAIL rst_pending got v=%b gt=%b cnt=%0d exp 1 1 1", v0, g0, gc0);
    end
    #2;
    rst_n_in = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({r0, v0, g0, e0, l0, gc0, ec0, lc0} !== {5'b10000, 12'd0}) begin
      errors++;
      $display("[TB] FAIL rst_async got ready/valid/flags=%b cnt=%0d/%0d/%0d exp 10000 0/0/0", {r0, v0, g0, e0, l0}, gc0, ec0, lc0);
    end
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    ready_in = 1'b1;
    tick();
    checks++;
    if (v0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_release got valid=%b exp 0", v0);
    end
  endtask

  task automatic test_width_sweep();
    bit expR;
    do_reset();
    for (int n = 0; n < 1000; n++) begin
      valid_in   = ($urandom_range(0, 3) != 0);
      ready_in   = ($urandom_range(0, 3) != 0);
      signed_in  = $urandom_range(0, 1);
      cnt_clr_in = ($urandom_range(0, 63) == 0);
      a = {1'($urandom), 32'($urandom)};
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ (33'd1 << $urandom_range(0, 32));
        default: b = {1'($urandom), 32'($urandom)};
      endcase
      #1;
      for (int i = 0; i < 3; i++) begin
        expR = !mV[i] || ready_in;
        checks++;
        if (obsR[i] !== expR) begin
          errors++;
          $display("[TB] FAIL sweep_ready inst%0d cyc%0d got %b exp %b", i, n, obsR[i], expR);
        end
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({obsV[i], obsF[i]} !== {mV[i], mF[i]}) begin
          errors++;
          $display("[TB] FAIL sweep_flags inst%0d cyc%0d got v/flags=%b exp %b", i, n, {obsV[i], obsF[i]}, {mV[i], mF[i]});
        end
        checks++;
        if (obsGc[i] !== 16'(mCnt[i][0]) || obsEc[i] !== 16'(mCnt[i][1]) || obsLc[i] !== 16'(mCnt[i][2])) begin
          errors++;
          $display("[TB] FAIL sweep_counters inst%0d cyc%0d got %0d/%0d/%0d exp %0d/%0d/%0d", i, n,
                   obsGc[i], obsEc[i], obsLc[i], mCnt[i][0], mCnt[i][1], mCnt[i][2]);
        end
      end
    end
    valid_in = 1'b0;
    cnt_clr_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mode();
    test_backpressure();
    test_saturation();
    test_clear_collision();
    test_reset_midstream();
    test_width_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
